// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Arbitrates two write requesters (ALU = req0, load unit = req1) onto the
// single register-file write port through a one-entry output stage.
// Optional feature: define REGFILE_WRITE_BYPASS_EN to forward the staged
// write onto the read data outputs PA/PB.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   reqN_valid/rd/data       write requests (N = 0 ALU, 1 load unit)
//   reqN_ready               request accepted this cycle (combinational)
//   freeze                   pipeline freeze: blocks the write, holds stage
//   RW, PW, enable           register-file write port
//   RA, RB                   read indices presented to the register file
//   rf_PA, rf_PB             register-file read data
//   PA, PB                   read data to the pipeline
//   stall_cnt                saturating count of request-stall cycles
module regfile_write_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              freeze,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] PW,
    output logic              enable,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [DATA_W-1:0] rf_PA,
    input  logic [DATA_W-1:0] rf_PB,
    output logic [DATA_W-1:0] PA,
    output logic [DATA_W-1:0] PB,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned CNT_W = 16;

    logic              stg_valid;
    logic [ADDR_W-1:0] stg_rd;
    logic [DATA_W-1:0] stg_data;
    logic              lp;          // index of the last granted requester

    logic              can_load;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [ADDR_W-1:0] acc_rd;
    logic [DATA_W-1:0] acc_data;
    logic              load;
    logic              stall;

    // Round-robin grant: on conflict the requester not named by lp wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = lp;
            grant1 = ~lp;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign can_load   = ~stg_valid | ~freeze;
    assign req0_ready = grant0 & can_load;
    assign req1_ready = grant1 & can_load;
    assign accept     = req0_ready | req1_ready;
    assign acc_rd     = req0_ready ? req0_rd   : req1_rd;
    assign acc_data   = req0_ready ? req0_data : req1_data;
    // Writes to x0 are consumed but never staged.
    assign load       = accept & (acc_rd != '0);
    assign stall      = (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready);

    assign RW     = stg_rd;
    assign PW     = stg_data;
    assign enable = stg_valid & ~freeze;

    // Stage, round-robin pointer and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= 1'b0;
            stg_rd    <= '0;
            stg_data  <= '0;
            lp        <= 1'b1;
            stall_cnt <= '0;
        end else begin
            // A load on a draining edge replaces the entry with no bubble.
            if (load) begin
                stg_valid <= 1'b1;
                stg_rd    <= acc_rd;
                stg_data  <= acc_data;
            end else if (enable) begin
                stg_valid <= 1'b0;
            end

            if (req0_ready) begin
                lp <= 1'b0;
            end else if (req1_ready) begin
                lp <= 1'b1;
            end

            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    // Forward the write in flight so readers see it in the same cycle.
    assign PA = (enable && (RW == RA) && (RA != '0)) ? PW : rf_PA;
    assign PB = (enable && (RW == RB) && (RB != '0)) ? PW : rf_PB;
`else
    logic unused_read_idx;
    assign unused_read_idx = ^{RA, RB};
    assign PA = rf_PA;
    assign PB = rf_PB;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: a table of cycle-by-cycle vectors
// followed by directed sequences for conflict, freeze, bypass and reset.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_rd, req1_rd;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        freeze;
    logic [4:0]  RW, RA, RB;
    logic [31:0] PW, rf_PA, rf_PB, PA, PB;
    logic        enable;
    logic [15:0] stall_cnt;

    logic [31:0] rf [32];
    int          n_chk;
    int          n_err;
    logic [31:0] saved;
    logic [31:0] exp_byp;

    regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .freeze(freeze), .RW(RW), .PW(PW), .enable(enable),
        .RA(RA), .RB(RB), .rf_PA(rf_PA), .rf_PB(rf_PB), .PA(PA), .PB(PB),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file written by the DUT's write port.
    always @(posedge clk) begin
        if (enable) rf[RW] <= PW;
    end

    typedef struct {
        logic        r0v;
        logic [4:0]  r0rd;
        logic [31:0] r0d;
        logic        r1v;
        logic [4:0]  r1rd;
        logic [31:0] r1d;
        logic        frz;
        logic        e_r0;
        logic        e_r1;
        logic        e_en;
        logic [4:0]  e_rw;
        logic [31:0] e_pw;
        logic [15:0] e_st;
    } vec_t;

    vec_t vt [21];

    function automatic vec_t mk(input logic r0v, input logic [4:0] r0rd, input logic [31:0] r0d,
                                input logic r1v, input logic [4:0] r1rd, input logic [31:0] r1d,
                                input logic frz, input logic e_r0, input logic e_r1,
                                input logic e_en, input logic [4:0] e_rw, input logic [31:0] e_pw,
                                input logic [15:0] e_st);
        vec_t v;
        v.r0v = r0v; v.r0rd = r0rd; v.r0d = r0d;
        v.r1v = r1v; v.r1rd = r1rd; v.r1d = r1d;
        v.frz = frz; v.e_r0 = e_r0; v.e_r1 = e_r1;
        v.e_en = e_en; v.e_rw = e_rw; v.e_pw = e_pw; v.e_st = e_st;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
        req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
        freeze = 1'b0; RA = '0; RB = '0; rf_PA = '0; rf_PB = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst_n = 1'b0;
        clear_inputs();

        // Reset state; ready still follows the inputs during reset.
        req0_valid = 1'b1; req0_rd = 5'd6; req0_data = 32'h6;
        #2;
        chk("reset enable", 32'(enable), 32'd0);
        chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset req0_ready", 32'(req0_ready), 32'd1);
        chk("reset req1_ready", 32'(req1_ready), 32'd0);
        tick();
        chk("reset enable after edge", 32'(enable), 32'd0);
        clear_inputs();
        tick();
        rst_n = 1'b1;
        #1;

        //        r0v r0rd   r0d          r1v r1rd   r1d          frz r0 r1 en rw     pw           st
        vt[0]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 0, 5'd0,  32'h0,        16'd0);
        vt[1]  = mk(1, 5'd5,  32'hAA,       0, 5'd0,  32'h0,        0, 1, 0, 0, 5'd0,  32'h0,        16'd0);
        vt[2]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 1, 5'd5,  32'hAA,       16'd0);
        vt[3]  = mk(0, 5'd0,  32'h0,        1, 5'd0,  32'hFFFFFFFF, 0, 0, 1, 0, 5'd0,  32'h0,        16'd0);
        vt[4]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 0, 5'd0,  32'h0,        16'd0);
        vt[5]  = mk(1, 5'd3,  32'h11,       1, 5'd4,  32'h22,       0, 1, 0, 0, 5'd0,  32'h0,        16'd0);
        vt[6]  = mk(0, 5'd0,  32'h0,        1, 5'd4,  32'h22,       0, 0, 1, 1, 5'd3,  32'h11,       16'd1);
        vt[7]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 1, 5'd4,  32'h22,       16'd1);
        vt[8]  = mk(1, 5'd10, 32'h33,       1, 5'd11, 32'h44,       0, 1, 0, 0, 5'd0,  32'h0,        16'd1);
        vt[9]  = mk(1, 5'd12, 32'h55,       1, 5'd11, 32'h44,       0, 0, 1, 1, 5'd10, 32'h33,       16'd2);
        vt[10] = mk(1, 5'd12, 32'h55,       0, 5'd0,  32'h0,        0, 1, 0, 1, 5'd11, 32'h44,       16'd3);
        vt[11] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 0, 0, 5'd0,  32'h0,        16'd3);
        vt[12] = mk(0, 5'd0,  32'h0,        1, 5'd13, 32'h66,       1, 0, 0, 0, 5'd0,  32'h0,        16'd3);
        vt[13] = mk(0, 5'd0,  32'h0,        1, 5'd13, 32'h66,       0, 0, 1, 1, 5'd12, 32'h55,       16'd4);
        vt[14] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 0, 0, 5'd0,  32'h0,        16'd4);
        vt[15] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 1, 5'd13, 32'h66,       16'd4);
        vt[16] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 0, 5'd0,  32'h0,        16'd4);
        vt[17] = mk(1, 5'd14, 32'h77,       0, 5'd0,  32'h0,        1, 1, 0, 0, 5'd0,  32'h0,        16'd4);
        vt[18] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 0, 0, 5'd0,  32'h0,        16'd4);
        vt[19] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 1, 5'd14, 32'h77,       16'd4);
        vt[20] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 0, 5'd0,  32'h0,        16'd4);

        for (int i = 0; i < 21; i++) begin
            req0_valid = vt[i].r0v; req0_rd = vt[i].r0rd; req0_data = vt[i].r0d;
            req1_valid = vt[i].r1v; req1_rd = vt[i].r1rd; req1_data = vt[i].r1d;
            freeze = vt[i].frz;
            #1;
            chk($sformatf("row%0d req0_ready", i), 32'(req0_ready), 32'(vt[i].e_r0));
            chk($sformatf("row%0d req1_ready", i), 32'(req1_ready), 32'(vt[i].e_r1));
            chk($sformatf("row%0d enable", i), 32'(enable), 32'(vt[i].e_en));
            chk($sformatf("row%0d stall_cnt", i), 32'(stall_cnt), 32'(vt[i].e_st));
            if (vt[i].e_en) begin
                chk($sformatf("row%0d RW", i), 32'(RW), 32'(vt[i].e_rw));
                chk($sformatf("row%0d PW", i), PW, vt[i].e_pw);
            end
            tick();
        end
        clear_inputs();
        #1;
        chk("rf x0 untouched", rf[0], 32'h0);
        chk("rf[5]", rf[5], 32'hAA);
        chk("rf[4]", rf[4], 32'h22);
        chk("rf[12]", rf[12], 32'h55);
        chk("rf[14]", rf[14], 32'h77);

        // Conflict right after reset: req0 first, then req1, one stall.
        do_reset();
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h11;
        req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h22;
        #1;
        chk("conf req0_ready", 32'(req0_ready), 32'd1);
        chk("conf req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("conf req1_ready c2", 32'(req1_ready), 32'd1);
        chk("conf enable c2", 32'(enable), 32'd1);
        chk("conf RW c2", 32'(RW), 32'd3);
        tick();
        req1_valid = 1'b0;
        #1;
        chk("conf enable c3", 32'(enable), 32'd1);
        chk("conf RW c3", 32'(RW), 32'd4);
        chk("conf PW c3", PW, 32'h22);
        chk("conf stall_cnt", 32'(stall_cnt), 32'd1);
        tick();
        chk("conf idle enable", 32'(enable), 32'd0);

        // Freeze with a staged write and req1 waiting.
        do_reset();
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h70;
        #1;
        tick();
        req0_valid = 1'b0;
        freeze = 1'b1;
        req1_valid = 1'b1; req1_rd = 5'd8; req1_data = 32'h80;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("frz c%0d enable", c), 32'(enable), 32'd0);
            chk($sformatf("frz c%0d req1_ready", c), 32'(req1_ready), 32'd0);
            tick();
        end
        freeze = 1'b0;
        #1;
        chk("frz stall_cnt", 32'(stall_cnt), 32'd3);
        chk("frz release enable", 32'(enable), 32'd1);
        chk("frz release RW", 32'(RW), 32'd7);
        chk("frz release req1_ready", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        #1;
        chk("frz rf[7]", rf[7], 32'h70);
        chk("frz next RW", 32'(RW), 32'd8);
        chk("frz next enable", 32'(enable), 32'd1);
        tick();

        // Read bypass of the staged write.
        do_reset();
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h12345678;
        #1;
        tick();
        req0_valid = 1'b0;
        RA = 5'd9; rf_PA = 32'h0;
        RB = 5'd2; rf_PB = 32'h0000BEEF;
`ifdef REGFILE_WRITE_BYPASS_EN
        exp_byp = 32'h12345678;
`else
        exp_byp = 32'h0;
`endif
        #1;
        chk("byp PA hit", PA, exp_byp);
        chk("byp PB miss", PB, 32'h0000BEEF);
        RA = 5'd0; rf_PA = 32'h0000CAFE;
        #1;
        chk("byp PA ra0", PA, 32'h0000CAFE);
        RA = 5'd9; rf_PA = 32'h0; freeze = 1'b1;
        #1;
        chk("byp PA frozen", PA, 32'h0);
        freeze = 1'b0;
        tick();
        clear_inputs();

        // Reset in the middle of a pending write discards it.
        saved = rf[12];
        do_reset();
        req0_valid = 1'b1; req0_rd = 5'd12; req0_data = 32'h00000999;
        req1_valid = 1'b1; req1_rd = 5'd20; req1_data = 32'h1;
        #1;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("rst pre enable", 32'(enable), 32'd1);
        chk("rst pre stall_cnt", 32'(stall_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst enable", 32'(enable), 32'd0);
        chk("rst stall_cnt", 32'(stall_cnt), 32'd0);
        tick();
        chk("rst rf[12] kept", rf[12], saved);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h1;
        req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'h2;
        #1;
        chk("rst lp req0_ready", 32'(req0_ready), 32'd1);
        chk("rst lp req1_ready", 32'(req1_ready), 32'd0);
        tick();
        clear_inputs();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
